macc_dot_scheduler: RTL
=======================

Name: macc_dot_scheduler

Overview:
Sequencer that computes a length-N dot product (sum of a[i]*b[i]) on a single shared MACC instance (IEEE-754 single precision, fused a*b+c, fixed pipeline latency LATENCY). It sits between the operand stream source (weight/activation fetch) and MACC.
- Hides MACC latency by rotating LATENCY independent partial sums.
- Serially reduces the partial sums through the same MACC with b=1.0.
- Emits one scalar result per job on an AXI-stream-style output.

Parameters:
BITWIDTH, 32, data width (IEEE-754 single)
LATENCY, 8, MACC issue-to-result latency in cycles (>=1); also the number of partial-sum slots
LENWIDTH, 16, width of job length field

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
start  in  1  one-cycle job start pulse; accepted only in IDLE when flush complete
cfg_len  in  LENWIDTH  number of a/b pairs in job; sampled on accepted start
busy  out  1  high from accepted start until output handshake
s_axis_ab_a_tdata  in  BITWIDTH  operand a
s_axis_ab_b_tdata  in  BITWIDTH  operand b
s_axis_ab_tvalid  in  1  a/b pair valid
s_axis_ab_tready  out  1  pair accepted when tvalid&&tready
m_macc_a_tdata  out  BITWIDTH  MACC a
m_macc_b_tdata  out  BITWIDTH  MACC b
m_macc_c_tdata  out  BITWIDTH  MACC c
m_macc_tvalid  out  1  drives all three MACC tvalid inputs
s_macc_result_tdata  in  BITWIDTH  MACC result
s_macc_result_tvalid  in  1  MACC result valid
m_axis_dot_tdata  out  BITWIDTH  final dot product
m_axis_dot_tvalid  out  1  result valid
m_axis_dot_tready  in  1  result accepted

Behaviour:
- Reset: all outputs 0, state IDLE, counters and slot valid bits cleared, flush counter loaded with LATENCY.
- Flush: flush counter decrements each cycle to 0; start is ignored while it is nonzero. This discards stale MACC results in flight at reset. s_macc_result_tvalid is ignored in IDLE.
- IDLE: on start with flush done, latch cfg_len, busy<=1, issue_cnt=wb_cnt=0.
  - cfg_len==0: go to OUTPUT with result 0x00000000.
  - Otherwise go to ACCUM.
- ACCUM:
  - s_axis_ab_tready = 1 while issue_cnt < len.
  - Each accepted pair issues to MACC next cycle (registered, 1-cycle): slot = issue_cnt mod LATENCY; c = psum[slot] if slot valid, else 0.
  - issue_cnt increments.
  - No MACC backpressure. Slot reuse is safe because reuse is at least LATENCY cycles later.
- Writeback (ACCUM/DRAIN): each s_macc_result_tvalid writes psum[wb_cnt mod LATENCY] and sets its valid bit; wb_cnt increments. Results return in order.
- DRAIN: entered when issue_cnt==len. Wait until wb_cnt==len.
  - P = min(len, LATENCY).
  - acc <= psum[0], j=1.
  - P==1: go to OUTPUT; otherwise go to RED_ISSUE.
- RED_ISSUE: one-cycle MACC issue with a=psum[j], b=0x3F800000 (1.0), c=acc; go to RED_WAIT.
- RED_WAIT: on result, acc <= result, j++. Go to RED_ISSUE if j<P, else OUTPUT.
- OUTPUT:
  - m_axis_dot_tvalid=1 and tdata=acc, both held stable until tready.
  - On handshake: busy<=0, valid bits cleared, go to IDLE.
  - Same-cycle start is ignored.
- m_macc_tvalid is low except on issue cycles; MACC data outputs are 0 when not valid.
- start while busy: ignored. areset mid-job: immediate return to IDLE plus flush; the partial job is discarded, no output.
- Counters are LENWIDTH bits; len up to 2^LENWIDTH-1, no wrap.

Optional Feature:
MACC_DOT_RELU_EN:
- Defined: in OUTPUT, if acc[BITWIDTH-1]==1 (negative, incl. -0.0), m_axis_dot_tdata = 0x00000000.
- Undefined: raw acc is output. All other behaviour is identical.

Decomposition:
- Package macc_dot_pkg: state encoding (IDLE, ACCUM, DRAIN, RED_ISSUE, RED_WAIT, OUTPUT), FP_ZERO=32'h00000000, FP_ONE=32'h3F800000.
- Sub-module macc_psum_bank: LATENCY x BITWIDTH register file with per-slot valid bits; one read port (issue) and one write port (writeback); synchronous clear of valid bits.

Test Plan:
- len=4, a={1.0,2.0,3.0,4.0} (3F800000,40000000,40400000,40800000), b=all 1.0, LATENCY=8 -> single output 41200000 (10.0); busy low after handshake.
- len=1, a=2.0 b=3.0 -> 40C00000 (6.0), no reduction issues (exactly one m_macc_tvalid pulse).
- len=0 -> output 00000000 one cycle after start, zero MACC issues.
- len=20, a=b=1.0, random s_axis_ab_tvalid gaps -> 41A00000 (20.0); exactly 20+7 MACC issues; tready low after 20 accepts.
- Output backpressure: m_axis_dot_tready low 10 cycles -> tdata/tvalid stable; start pulses during hold ignored; areset mid-ACCUM then new len=1 job -> correct result, no stale writeback.
- a=-1.0 (BF800000), b=2.0, len=1 -> C0000000 without MACC_DOT_RELU_EN; 00000000 with it.

Source files
------------

// File: rtl/macc_dot_pkg.sv
// Shared FSM encoding and IEEE-754 constants for the dot-product MACC sequencer.
package macc_dot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDrain,
    StRedIssue,
    StRedWait,
    StOutput
  } state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/macc_psum_bank.sv
// Partial-sum register file: one combinational read port, one write port, per-slot valid bits.
module macc_psum_bank #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned LATENCY  = 8,
  parameter int unsigned SLOTW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                we,
  input  logic [SLOTW-1:0]    waddr,
  input  logic [BITWIDTH-1:0] wdata,
  input  logic [SLOTW-1:0]    raddr,
  output logic [BITWIDTH-1:0] rdata,
  output logic                rvalid
);

  logic [BITWIDTH-1:0] mem_q [LATENCY];
  logic [LATENCY-1:0]  vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (clr) begin
      vld_q <= '0;
    end else if (we) begin
      vld_q[waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata  = mem_q[raddr];
  assign rvalid = vld_q[raddr];

endmodule

// File: rtl/macc_dot_scheduler.sv
// Dot-product sequencer over one shared fused MACC; rotates LATENCY partial sums, then reduces.
// Optional build macro MACC_DOT_RELU_EN clamps negative results to +0.0 on the output.
module macc_dot_scheduler
  import macc_dot_pkg::*;
#(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned LATENCY  = 8,
  parameter int unsigned LENWIDTH = 16
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  input  logic [LENWIDTH-1:0] cfg_len,
  output logic                busy,
  input  logic [BITWIDTH-1:0] s_axis_ab_a_tdata,
  input  logic [BITWIDTH-1:0] s_axis_ab_b_tdata,
  input  logic                s_axis_ab_tvalid,
  output logic                s_axis_ab_tready,
  output logic [BITWIDTH-1:0] m_macc_a_tdata,
  output logic [BITWIDTH-1:0] m_macc_b_tdata,
  output logic [BITWIDTH-1:0] m_macc_c_tdata,
  output logic                m_macc_tvalid,
  input  logic [BITWIDTH-1:0] s_macc_result_tdata,
  input  logic                s_macc_result_tvalid,
  output logic [BITWIDTH-1:0] m_axis_dot_tdata,
  output logic                m_axis_dot_tvalid,
  input  logic                m_axis_dot_tready
);

  localparam int unsigned SlotW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned FlushW = $clog2(LATENCY + 1);

  state_e              state_q;
  logic [LENWIDTH-1:0] len_q, issue_cnt_q, wb_cnt_q, j_q, p, j_nxt;
  logic [SlotW-1:0]    issue_slot_q, wb_slot_q, iss_slot_q, rd_addr;
  logic [FlushW-1:0]   flush_q;
  logic                iss_q;
  logic [BITWIDTH-1:0] iss_a_q, iss_b_q, acc_q, rd_data, iss_c, dot_val;
  logic                rd_valid, ab_fire, wb_fire, start_ok, dot_fire;

  assign ab_fire  = s_axis_ab_tvalid && (state_q == StAccum);
  assign wb_fire  = s_macc_result_tvalid && (state_q == StAccum || state_q == StDrain) &&
                    (wb_cnt_q != len_q);
  assign start_ok = start && (state_q == StIdle) && (flush_q == '0);
  assign dot_fire = (state_q == StOutput) && m_axis_dot_tready;
  assign p        = (32'(len_q) < LATENCY) ? len_q : LENWIDTH'(LATENCY);
  assign j_nxt    = j_q + LENWIDTH'(1);

  assign rd_addr = iss_q ? iss_slot_q : ((state_q == StRedIssue) ? j_q[SlotW-1:0] : '0);

  macc_psum_bank #(
    .BITWIDTH (BITWIDTH),
    .LATENCY  (LATENCY),
    .SLOTW    (SlotW)
  ) u_bank (
    .clk    (aclk),
    .rst    (areset),
    .clr    (dot_fire),
    .we     (wb_fire),
    .waddr  (wb_slot_q),
    .wdata  (s_macc_result_tdata),
    .raddr  (rd_addr),
    .rdata  (rd_data),
    .rvalid (rd_valid)
  );

  // A slot reused exactly LATENCY cycles later sees its result on the bus that same cycle.
  assign iss_c = (wb_fire && wb_slot_q == iss_slot_q) ? s_macc_result_tdata :
                 (rd_valid ? rd_data : BITWIDTH'(FP_ZERO));

  always_comb begin
    m_macc_a_tdata = '0;
    m_macc_b_tdata = '0;
    m_macc_c_tdata = '0;
    m_macc_tvalid  = 1'b0;
    if (iss_q) begin
      m_macc_a_tdata = iss_a_q;
      m_macc_b_tdata = iss_b_q;
      m_macc_c_tdata = iss_c;
      m_macc_tvalid  = 1'b1;
    end else if (state_q == StRedIssue) begin
      m_macc_a_tdata = rd_data;
      m_macc_b_tdata = BITWIDTH'(FP_ONE);
      m_macc_c_tdata = acc_q;
      m_macc_tvalid  = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      issue_cnt_q  <= '0;
      wb_cnt_q     <= '0;
      j_q          <= '0;
      issue_slot_q <= '0;
      wb_slot_q    <= '0;
      iss_slot_q   <= '0;
      flush_q      <= FlushW'(LATENCY);
      iss_q        <= 1'b0;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      acc_q        <= '0;
    end else begin
      if (flush_q != '0) flush_q <= flush_q - FlushW'(1);
      iss_q <= ab_fire;
      if (ab_fire) begin
        iss_a_q      <= s_axis_ab_a_tdata;
        iss_b_q      <= s_axis_ab_b_tdata;
        iss_slot_q   <= issue_slot_q;
        issue_slot_q <= (issue_slot_q == SlotW'(LATENCY - 1)) ? '0 : issue_slot_q + SlotW'(1);
        issue_cnt_q  <= issue_cnt_q + LENWIDTH'(1);
      end
      if (wb_fire) begin
        wb_slot_q <= (wb_slot_q == SlotW'(LATENCY - 1)) ? '0 : wb_slot_q + SlotW'(1);
        wb_cnt_q  <= wb_cnt_q + LENWIDTH'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            len_q        <= cfg_len;
            issue_cnt_q  <= '0;
            wb_cnt_q     <= '0;
            issue_slot_q <= '0;
            wb_slot_q    <= '0;
            acc_q        <= BITWIDTH'(FP_ZERO);
            state_q      <= (cfg_len == '0) ? StOutput : StAccum;
          end
        end
        StAccum: begin
          if (ab_fire && issue_cnt_q == len_q - LENWIDTH'(1)) state_q <= StDrain;
        end
        StDrain: begin
          if (wb_cnt_q == len_q) begin
            acc_q   <= rd_data;
            j_q     <= LENWIDTH'(1);
            state_q <= (p == LENWIDTH'(1)) ? StOutput : StRedIssue;
          end
        end
        StRedIssue: state_q <= StRedWait;
        StRedWait: begin
          if (s_macc_result_tvalid) begin
            acc_q   <= s_macc_result_tdata;
            j_q     <= j_nxt;
            state_q <= (j_nxt < p) ? StRedIssue : StOutput;
          end
        end
        StOutput: begin
          if (m_axis_dot_tready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MACC_DOT_RELU_EN
  assign dot_val = acc_q[BITWIDTH-1] ? BITWIDTH'(FP_ZERO) : acc_q;
`else
  assign dot_val = acc_q;
`endif

  assign busy              = (state_q != StIdle);
  assign s_axis_ab_tready  = (state_q == StAccum);
  assign m_axis_dot_tvalid = (state_q == StOutput);
  assign m_axis_dot_tdata  = (state_q == StOutput) ? dot_val : '0;

endmodule
